// File: rtl/rs_issue_sel.sv
// rs_issue_sel: age-matrix oldest-ready pick, one-hot grant, stallable rs2 issue register.
// Macros: RS_ISSUE_PERF_EN adds saturating issue/stall counters; ASSERT enables the alloc/grant check.
package rs_issue_pkg;
   typedef struct packed {
      logic [5:0]  robid;
      logic [3:0]  uop;
      logic [15:0] imm;
   } t_uinstr_iss;
endpackage

module rs_issue_sel
   import rs_issue_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_ENTRIES-1:0] e_alloc_rs0,
   input  logic [NUM_ENTRIES-1:0] e_valid,
   input  logic [NUM_ENTRIES-1:0] e_req_issue_rs1,
   input  t_uinstr_iss            e_issue_pkt_rs1 [NUM_ENTRIES],
   output logic [NUM_ENTRIES-1:0] e_gnt_issue_rs1,
   output logic                   iss_valid_rs2,
   output t_uinstr_iss            iss_pkt_rs2,
   input  logic                   ex_stall_rs2
`ifdef RS_ISSUE_PERF_EN
   ,
   output logic [31:0]            perf_issue_cnt,
   output logic [31:0]            perf_stall_cnt
`endif
);

   logic [NUM_ENTRIES-1:0] r_older   [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] w_new_row [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] w_cand;
   logic [NUM_ENTRIES-1:0] w_sel_raw;
   logic [NUM_ENTRIES-1:0] w_sel;
   logic [NUM_ENTRIES-1:0] w_gnt;
   logic                   w_can_accept;
   t_uinstr_iss            w_pkt_mux;
   logic                   r_valid;
   t_uinstr_iss            r_pkt;

   // A newly allocated row marks every surviving valid entry plus lower-index same-cycle allocs as older.
   always_comb begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         w_new_row[i] = e_valid & ~w_gnt;
         for (int unsigned j = 0; j < i; j++) begin
            w_new_row[i][j] = w_new_row[i][j] | e_alloc_rs0[j];
         end
         w_new_row[i][i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            r_older[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (e_alloc_rs0[i]) begin
               r_older[i] <= w_new_row[i];
            end else begin
               r_older[i] <= r_older[i] & ~e_alloc_rs0;
            end
         end
      end
   end

   always_comb begin
      w_cand    = e_req_issue_rs1 & e_valid;
      w_sel_raw = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         w_sel_raw[i] = w_cand[i] & ~|(r_older[i] & w_cand);
      end
   end

   // Lowest-set-bit isolation keeps the grant one-hot even if the matrix were ever inconsistent.
   assign w_sel        = w_sel_raw & (~w_sel_raw + NUM_ENTRIES'(1));
   assign w_can_accept = ~r_valid | ~ex_stall_rs2;
   assign w_gnt        = w_sel & {NUM_ENTRIES{w_can_accept & reset_n}};

   always_comb begin
      w_pkt_mux = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (w_gnt[i]) begin
            w_pkt_mux = t_uinstr_iss'(w_pkt_mux | e_issue_pkt_rs1[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_pkt   <= '0;
      end else if (w_can_accept) begin
         r_valid <= |w_gnt;
         r_pkt   <= w_pkt_mux;
      end
   end

   assign e_gnt_issue_rs1 = w_gnt;
   assign iss_valid_rs2   = r_valid;
   assign iss_pkt_rs2     = r_pkt;

`ifdef RS_ISSUE_PERF_EN
   logic [31:0] r_issue_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_issue_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (|w_gnt && (r_issue_cnt != '1)) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
         end
         if (r_valid && ex_stall_rs2 && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign perf_issue_cnt = r_issue_cnt;
   assign perf_stall_cnt = r_stall_cnt;
`endif

`ifdef ASSERT
   a_no_alloc_on_gnt: assert property (@(posedge clk) disable iff (!reset_n)
      (e_alloc_rs0 & w_gnt) == '0);
`endif

endmodule
